// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_fifo_if
// Brief   : Character-in / FWFT-out signal bundle for the UART receive FIFO.
// Revision: 1.0 - initial release
// ============================================================================
interface uart_rx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] char_i;
  logic                 valid_i;
  logic [DATA_BITS-1:0] data_o;
  logic                 valid_o;
  logic                 ready_i;
  logic                 full_o;
  logic                 overrun_o;
  logic                 overrun_clr_i;

  modport slave (
    input  char_i, valid_i, ready_i, overrun_clr_i,
    output data_o, valid_o, full_o, overrun_o
  );

  modport master (
    output char_i, valid_i, ready_i, overrun_clr_i,
    input  data_o, valid_o, full_o, overrun_o
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_fifo
// Brief   : FWFT receive buffer behind the UART character-recovery stage with
//           sticky overrun flag. Optional level_o via UART_RX_FIFO_LEVEL_EN.
// Revision: 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 16
) (
  input  wire logic                   clk_i,
  input  wire logic                   rst_ni,
  uart_rx_fifo_if.slave               bus
`ifdef UART_RX_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0]      level_o
`endif
);

  localparam int           AW         = $clog2(DEPTH);
  localparam logic [AW:0]  c_PTR_ONE  = {{AW{1'b0}}, 1'b1};

  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [AW:0]          r_wr_ptr;
  logic [AW:0]          r_rd_ptr;
  logic                 r_valid;
  logic                 r_full;
  logic                 r_overrun;

  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic [AW:0]          w_wr_nxt;
  logic [AW:0]          w_rd_nxt;

  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign w_pop    = r_valid & bus.ready_i;
  assign w_push   = bus.valid_i & (~r_full | w_pop);
  assign w_drop   = bus.valid_i & r_full & ~w_pop;
  assign w_wr_nxt = w_push ? (r_wr_ptr + c_PTR_ONE) : r_wr_ptr;
  assign w_rd_nxt = w_pop  ? (r_rd_ptr + c_PTR_ONE) : r_rd_ptr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_valid   <= 1'b0;
      r_full    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_wr_ptr  <= w_wr_nxt;
      r_rd_ptr  <= w_rd_nxt;
      r_valid   <= (w_wr_nxt != w_rd_nxt);
      r_full    <= (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]) &&
                   (w_wr_nxt[AW] != w_rd_nxt[AW]);
      // A new drop outranks a same-cycle clear.
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (bus.overrun_clr_i) begin
        r_overrun <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= bus.char_i;
    end
  end

  assign bus.data_o    = r_mem[r_rd_ptr[AW-1:0]];
  assign bus.valid_o   = r_valid;
  assign bus.full_o    = r_full;
  assign bus.overrun_o = r_overrun;

`ifdef UART_RX_FIFO_LEVEL_EN
  assign level_o = r_wr_ptr - r_rd_ptr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_rx_fifo
// Brief   : Directed self-checking bench for uart_rx_fifo (DEPTH=16, 8-bit).
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;
  localparam int DATA_BITS = 8;
  localparam int DEPTH     = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DATA_BITS(DATA_BITS)) bus ();

`ifdef UART_RX_FIFO_LEVEL_EN
  logic [4:0] level;
`endif

  uart_rx_fifo #(.DATA_BITS(DATA_BITS), .DEPTH(DEPTH)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .bus     (bus)
`ifdef UART_RX_FIFO_LEVEL_EN
    ,
    .level_o (level)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < DEPTH; i++) begin
      bus.char_i  = base + 8'(i);
      bus.valid_i = 1'b1;
      tick();
      chk("fill_full", 32'(bus.full_o), 32'(i == DEPTH - 1));
    end
    bus.valid_i = 1'b0;
  endtask

  task automatic drain(input logic [7:0] base, input int n);
    bus.ready_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk("drain_valid", 32'(bus.valid_o), 32'd1);
      chk("drain_data", 32'(bus.data_o), 32'(base + 8'(i)));
      tick();
    end
    bus.ready_i = 1'b0;
    chk("drain_empty", 32'(bus.valid_o), 32'd0);
  endtask

  initial begin
    bus.char_i        = '0;
    bus.valid_i       = 1'b0;
    bus.ready_i       = 1'b0;
    bus.overrun_clr_i = 1'b0;

    // Reset state
    repeat (2) tick();
    chk("rst_valid", 32'(bus.valid_o), 32'd0);
    chk("rst_full", 32'(bus.full_o), 32'd0);
    chk("rst_overrun", 32'(bus.overrun_o), 32'd0);
`ifdef UART_RX_FIFO_LEVEL_EN
    chk("rst_level", 32'(level), 32'd0);
`endif
    rst_n = 1'b1;

    // 1: single push then pop
    bus.char_i  = 8'hA5;
    bus.valid_i = 1'b1;
    tick();
    bus.valid_i = 1'b0;
    chk("t1_valid", 32'(bus.valid_o), 32'd1);
    chk("t1_data", 32'(bus.data_o), 32'hA5);
    chk("t1_full", 32'(bus.full_o), 32'd0);
`ifdef UART_RX_FIFO_LEVEL_EN
    chk("t1_level", 32'(level), 32'd1);
`endif
    bus.ready_i = 1'b1;
    tick();
    bus.ready_i = 1'b0;
    chk("t1_valid_after_pop", 32'(bus.valid_o), 32'd0);
`ifdef UART_RX_FIFO_LEVEL_EN
    chk("t1_level_after_pop", 32'(level), 32'd0);
`endif
    // ready while empty must not disturb anything
    bus.ready_i = 1'b1;
    tick();
    bus.ready_i = 1'b0;
    chk("t1_ready_empty", 32'(bus.valid_o), 32'd0);

    // 2: fill and drain in order
    fill(8'h00);
`ifdef UART_RX_FIFO_LEVEL_EN
    chk("t2_level", 32'(level), 32'd16);
`endif
    drain(8'h00, DEPTH);
    chk("t2_full_after", 32'(bus.full_o), 32'd0);

    // 3: overrun drops the character
    fill(8'h00);
    bus.char_i  = 8'h55;
    bus.valid_i = 1'b1;
    tick();
    bus.valid_i = 1'b0;
    chk("t3_overrun", 32'(bus.overrun_o), 32'd1);
    chk("t3_full", 32'(bus.full_o), 32'd1);
    drain(8'h00, DEPTH);
    chk("t3_overrun_sticky", 32'(bus.overrun_o), 32'd1);
    bus.overrun_clr_i = 1'b1;
    tick();
    bus.overrun_clr_i = 1'b0;
    chk("t3_overrun_clr", 32'(bus.overrun_o), 32'd0);

    // 4: push into full FIFO while popping
    fill(8'h00);
    bus.char_i  = 8'h77;
    bus.valid_i = 1'b1;
    bus.ready_i = 1'b1;
    chk("t4_head", 32'(bus.data_o), 32'h00);
    tick();
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    chk("t4_no_overrun", 32'(bus.overrun_o), 32'd0);
    chk("t4_full", 32'(bus.full_o), 32'd1);
    bus.ready_i = 1'b1;
    for (int i = 1; i < DEPTH; i++) begin
      chk("t4_data", 32'(bus.data_o), 32'(i));
      tick();
    end
    chk("t4_last_valid", 32'(bus.valid_o), 32'd1);
    chk("t4_last_data", 32'(bus.data_o), 32'h77);
    tick();
    bus.ready_i = 1'b0;
    chk("t4_empty", 32'(bus.valid_o), 32'd0);

    // 5: set wins over clear
    fill(8'h00);
    bus.char_i  = 8'h55;
    bus.valid_i = 1'b1;
    tick();
    chk("t5_overrun_set", 32'(bus.overrun_o), 32'd1);
    bus.char_i        = 8'h66;
    bus.overrun_clr_i = 1'b1;
    tick();
    bus.valid_i = 1'b0;
    chk("t5_set_wins", 32'(bus.overrun_o), 32'd1);
    tick();
    bus.overrun_clr_i = 1'b0;
    chk("t5_clear", 32'(bus.overrun_o), 32'd0);
    drain(8'h00, DEPTH);

    // 6: streaming with continuous ready, pointers wrap
    bus.ready_i = 1'b1;
    for (int k = 0; k < 40; k++) begin
      bus.char_i  = 8'h80 + 8'(k);
      bus.valid_i = 1'b1;
      tick();
      chk("t6_valid", 32'(bus.valid_o), 32'd1);
      chk("t6_data", 32'(bus.data_o), 32'(8'h80 + 8'(k)));
      chk("t6_full", 32'(bus.full_o), 32'd0);
    end
    bus.valid_i = 1'b0;
    tick();
    bus.ready_i = 1'b0;
    chk("t6_empty", 32'(bus.valid_o), 32'd0);

    // Async reset with a full FIFO
    fill(8'h10);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.valid_o), 32'd0);
    chk("arst_full", 32'(bus.full_o), 32'd0);
`ifdef UART_RX_FIFO_LEVEL_EN
    chk("arst_level", 32'(level), 32'd0);
`endif
    tick();
    rst_n = 1'b1;
    bus.char_i  = 8'h3C;
    bus.valid_i = 1'b1;
    tick();
    bus.valid_i = 1'b0;
    chk("post_rst_valid", 32'(bus.valid_o), 32'd1);
    chk("post_rst_data", 32'(bus.data_o), 32'h3C);
`ifdef UART_RX_FIFO_LEVEL_EN
    chk("post_rst_level", 32'(level), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
